// File: rtl/bios_pkg.sv
// Shared BIOS byte-protocol types: wire opcodes, host request ops and host FSM states.
package bios_pkg;

  typedef enum logic [7:0] {
    BOP_NOP     = 8'h00,
    BOP_BOOT    = 8'h01,
    BOP_RST     = 8'h02,
    BOP_READ    = 8'h03,
    BOP_WRITE   = 8'h04,
    BOP_ADDR_LO = 8'h05,
    BOP_ADDR_HI = 8'h06
  } bios_opcode_t;

  typedef enum logic [2:0] {
    HOP_NOP   = 3'd0,
    HOP_BOOT  = 3'd1,
    HOP_RST   = 3'd2,
    HOP_READ  = 3'd3,
    HOP_WRITE = 3'd4
  } host_op_t;

  typedef logic [3:0] bios_host_state_t;

  localparam bios_host_state_t S_IDLE     = 4'd0;
  localparam bios_host_state_t S_LO_OP    = 4'd1;
  localparam bios_host_state_t S_LO_A     = 4'd2;
  localparam bios_host_state_t S_LO_B     = 4'd3;
  localparam bios_host_state_t S_HI_OP    = 4'd4;
  localparam bios_host_state_t S_HI_A     = 4'd5;
  localparam bios_host_state_t S_HI_B     = 4'd6;
  localparam bios_host_state_t S_CMD_OP   = 4'd7;
  localparam bios_host_state_t S_CMD_ARG  = 4'd8;
  localparam bios_host_state_t S_WAIT_RSP = 4'd9;
  localparam bios_host_state_t S_RSP      = 4'd10;

  function automatic bios_opcode_t host_opcode(host_op_t op);
    case (op)
      HOP_BOOT:  return BOP_BOOT;
      HOP_RST:   return BOP_RST;
      HOP_READ:  return BOP_READ;
      HOP_WRITE: return BOP_WRITE;
      default:   return BOP_NOP;
    endcase
  endfunction

endpackage

// File: rtl/bios_host.sv
// BIOS host initiator: serialises host requests into BIOS command bytes, caching the
// last sent address so unchanged halves are skipped, and collects READ responses.
module bios_host
  import bios_pkg::*;
#(
  parameter int ADDR_WIDTH     = 31,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clk_en,
  input  logic                  i_cmd_valid,
  output logic                  o_cmd_ready,
  input  logic [2:0]            i_cmd_op,
  input  logic [ADDR_WIDTH:0]   i_cmd_addr,
  input  logic [7:0]            i_cmd_data,
  output logic                  o_rsp_valid,
  input  logic                  i_rsp_ready,
  output logic [7:0]            o_rsp_data,
  output logic                  o_rsp_timeout,
  output logic [7:0]            o_data,
  output logic                  o_valid,
  input  logic                  i_out_ready,
  input  logic [7:0]            i_data,
  input  logic                  i_valid,
  output logic                  o_in_ready
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  bios_host_state_t    state_q, state_d;
  host_op_t            op_q, op_d;
  logic [ADDR_WIDTH:0] addr_q, addr_d;
  logic [7:0]          wdata_q, wdata_d;
  logic [ADDR_WIDTH:0] cache_q, cache_d;
  logic                cvld_q, cvld_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic [7:0]          rsp_data_q, rsp_data_d;
  logic                rsp_to_q, rsp_to_d;
  logic [7:0]          odata_q, odata_d;
  logic                ovalid_q, ovalid_d;

  logic capture, out_hs, in_hs, lo_need, hi_need, addr_op;

  assign o_cmd_ready   = (state_q == S_IDLE);
  assign o_in_ready    = (state_q == S_IDLE) || (state_q == S_WAIT_RSP);
  assign o_valid       = ovalid_q;
  assign o_data        = odata_q;
  assign o_rsp_valid   = rsp_valid_q;
  assign o_rsp_data    = rsp_data_q;
  assign o_rsp_timeout = rsp_to_q;

  assign capture = clk_en && i_cmd_valid && (state_q == S_IDLE);
  assign out_hs  = clk_en && ovalid_q && i_out_ready;
  assign in_hs   = clk_en && i_valid && o_in_ready;

  always_comb begin
    op_d    = op_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    if (capture) begin
      op_d    = (i_cmd_op > 3'd4) ? HOP_NOP : host_op_t'(i_cmd_op);
      addr_d  = i_cmd_addr;
      wdata_d = i_cmd_data;
    end
  end

  // Cache never changes mid-sequence, so the need flags hold for the whole command.
  assign lo_need = !cvld_q || (addr_d[15:0]  != cache_q[15:0]);
  assign hi_need = !cvld_q || (addr_d[31:16] != cache_q[31:16]);
  assign addr_op = (op_d == HOP_READ) || (op_d == HOP_WRITE);

  always_comb begin
    state_d     = state_q;
    cache_d     = cache_q;
    cvld_d      = cvld_q;
    cnt_d       = cnt_q;
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    rsp_to_d    = rsp_to_q;
    case (state_q)
      S_IDLE: if (capture) begin
        if (addr_op) state_d = lo_need ? S_LO_OP : (hi_need ? S_HI_OP : S_CMD_OP);
        else         state_d = S_CMD_OP;
      end
      S_LO_OP: if (out_hs) state_d = S_LO_A;
      S_LO_A:  if (out_hs) state_d = S_LO_B;
      S_LO_B:  if (out_hs) state_d = hi_need ? S_HI_OP : S_CMD_OP;
      S_HI_OP: if (out_hs) state_d = S_HI_A;
      S_HI_A:  if (out_hs) state_d = S_HI_B;
      S_HI_B:  if (out_hs) state_d = S_CMD_OP;
      S_CMD_OP: if (out_hs) begin
        case (op_q)
          HOP_READ: begin
            state_d = S_WAIT_RSP;
            cache_d = addr_q;
            cvld_d  = 1'b1;
          end
          HOP_WRITE: begin
            state_d = S_CMD_ARG;
            cache_d = addr_q;
            cvld_d  = 1'b1;
          end
          HOP_BOOT, HOP_RST: begin
            state_d = S_IDLE;
            cvld_d  = 1'b0;
          end
          default: state_d = S_IDLE;
        endcase
      end
      S_CMD_ARG: if (out_hs) state_d = S_IDLE;
      S_WAIT_RSP: begin
        if (in_hs) begin
          state_d     = S_RSP;
          rsp_valid_d = 1'b1;
          rsp_data_d  = i_data;
          rsp_to_d    = 1'b0;
          cnt_d       = '0;
        end else if (clk_en) begin
          if (cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
            state_d     = S_RSP;
            rsp_valid_d = 1'b1;
            rsp_data_d  = 8'h00;
            rsp_to_d    = 1'b1;
            cvld_d      = 1'b0;
            cnt_d       = '0;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      S_RSP: if (clk_en && i_rsp_ready) begin
        state_d     = S_IDLE;
        rsp_valid_d = 1'b0;
        cnt_d       = '0;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Output byte is registered from the next state so o_valid never sees i_out_ready.
  always_comb begin
    odata_d  = 8'h00;
    ovalid_d = 1'b1;
    case (state_d)
      S_LO_OP:   odata_d = BOP_ADDR_LO;
      S_LO_A:    odata_d = addr_d[7:0];
      S_LO_B:    odata_d = addr_d[15:8];
      S_HI_OP:   odata_d = BOP_ADDR_HI;
      S_HI_A:    odata_d = addr_d[23:16];
      S_HI_B:    odata_d = addr_d[31:24];
      S_CMD_OP:  odata_d = host_opcode(op_d);
      S_CMD_ARG: odata_d = wdata_d;
      default:   ovalid_d = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      op_q        <= HOP_NOP;
      addr_q      <= '0;
      wdata_q     <= 8'h00;
      cache_q     <= '0;
      cvld_q      <= 1'b0;
      cnt_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= 8'h00;
      rsp_to_q    <= 1'b0;
      odata_q     <= 8'h00;
      ovalid_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      cache_q     <= cache_d;
      cvld_q      <= cvld_d;
      cnt_q       <= cnt_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_to_q    <= rsp_to_d;
      odata_q     <= odata_d;
      ovalid_q    <= ovalid_d;
    end
  end

endmodule

// File: tb/tb_bios_host.sv
// Randomised bench for bios_host against a request-level byte-stream and cache model.
module tb_bios_host;
  localparam int TO = 16;

  logic        clk = 1'b0;
  logic        rst, clk_en, i_cmd_valid, i_rsp_ready, i_out_ready, i_valid;
  logic [2:0]  i_cmd_op;
  logic [31:0] i_cmd_addr;
  logic [7:0]  i_cmd_data, i_data;
  logic        o_cmd_ready, o_rsp_valid, o_rsp_timeout, o_valid, o_in_ready;
  logic [7:0]  o_rsp_data, o_data;

  always #5 clk = ~clk;

  bios_host #(.ADDR_WIDTH(31), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst), .clk_en(clk_en),
    .i_cmd_valid(i_cmd_valid), .o_cmd_ready(o_cmd_ready), .i_cmd_op(i_cmd_op),
    .i_cmd_addr(i_cmd_addr), .i_cmd_data(i_cmd_data),
    .o_rsp_valid(o_rsp_valid), .i_rsp_ready(i_rsp_ready), .o_rsp_data(o_rsp_data),
    .o_rsp_timeout(o_rsp_timeout),
    .o_data(o_data), .o_valid(o_valid), .i_out_ready(i_out_ready),
    .i_data(i_data), .i_valid(i_valid), .o_in_ready(o_in_ready)
  );

  int n_tests = 0, n_fail = 0;
  int rdy_mode = 0, en_mode = 0;
  logic [7:0] got[$], exp_q[$];
  bit   mcv = 1'b0;
  logic [31:0] mca = '0;
  bit   is_rd, waiting, answered;
  int   wcnt, r_delay;
  logic [7:0] r_data;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // One clock: record handshakes seen before the edge, drive new inputs after it.
  task automatic tick();
    bit hs_out, in_hs, stall, frz;
    logic [7:0] pdat;
    logic [10:0] snap;
    hs_out = clk_en && o_valid && i_out_ready && !rst;
    in_hs  = clk_en && i_valid && o_in_ready && !rst;
    stall  = o_valid && !hs_out && !rst;
    frz    = !clk_en && !rst;
    pdat   = o_data;
    snap   = {o_valid, o_cmd_ready, o_rsp_valid, o_data};
    if (o_valid) chk("inrdy_busy", 32'(o_in_ready), 0);
    if (hs_out) got.push_back(o_data);
    if (waiting && clk_en && !rst) wcnt++;
    if (hs_out && is_rd && got.size() == exp_q.size()) begin
      waiting = 1'b1;
      wcnt    = 0;
    end
    @(posedge clk); #1;
    if (in_hs) i_valid = 1'b0;
    clk_en = (en_mode == 0) ? 1'b1 : ($urandom_range(3) != 0);
    case (rdy_mode)
      0:       i_out_ready = 1'b1;
      1:       i_out_ready = ~i_out_ready;
      default: i_out_ready = $urandom_range(1);
    endcase
    if (waiting && !answered && r_delay >= 0 && wcnt >= r_delay) begin
      i_valid  = 1'b1;
      i_data   = r_data;
      answered = 1'b1;
    end
    @(negedge clk);
    if (stall) begin
      chk("hold_valid", 32'(o_valid), 1);
      chk("hold_data", 32'(o_data), 32'(pdat));
    end
    if (frz) chk("freeze", 32'({o_valid, o_cmd_ready, o_rsp_valid, o_data}), 32'(snap));
  endtask

  // Expected byte stream straight from the protocol rules.
  task automatic model(input logic [2:0] op, input logic [31:0] addr, input logic [7:0] data);
    int mop;
    mop = (op > 3'd4) ? 0 : int'(op);
    exp_q.delete();
    if (mop == 3 || mop == 4) begin
      if (!mcv || addr[15:0] != mca[15:0]) begin
        exp_q.push_back(8'h05); exp_q.push_back(addr[7:0]); exp_q.push_back(addr[15:8]);
      end
      if (!mcv || addr[31:16] != mca[31:16]) begin
        exp_q.push_back(8'h06); exp_q.push_back(addr[23:16]); exp_q.push_back(addr[31:24]);
      end
      exp_q.push_back(8'(mop));
      if (mop == 4) exp_q.push_back(data);
      mcv = 1'b1;
      mca = addr;
    end else begin
      exp_q.push_back(8'(mop));
      if (mop == 1 || mop == 2) mcv = 1'b0;
    end
  endtask

  task automatic run_cmd(input logic [2:0] op, input logic [31:0] addr, input logic [7:0] data,
                         input int rd_delay, input logic [7:0] rd_data);
    int g;
    model(op, addr, data);
    got.delete();
    is_rd = (op == 3'd3); waiting = 1'b0; answered = 1'b0;
    r_delay = rd_delay; r_data = rd_data;
    i_cmd_op = op; i_cmd_addr = addr; i_cmd_data = data; i_cmd_valid = 1'b1;
    g = 0;
    while (!(o_cmd_ready && clk_en) && g < 500) begin tick(); g++; end
    tick();
    i_cmd_valid = 1'b0;
    g = 0;
    if (is_rd) begin
      while (!o_rsp_valid && g < 2000) begin tick(); g++; end
      chk("rsp_seen", 32'(o_rsp_valid), 1);
      if (rd_delay < 0) begin
        chk("to_cycles", wcnt, TO);
        chk("to_flag", 32'(o_rsp_timeout), 1);
        chk("to_data", 32'(o_rsp_data), 0);
        mcv = 1'b0;
      end else begin
        chk("rsp_flag", 32'(o_rsp_timeout), 0);
        chk("rsp_data", 32'(o_rsp_data), 32'(rd_data));
      end
      waiting = 1'b0;
      is_rd   = 1'b0;
      tick(); tick();
      chk("rsp_hold", 32'(o_rsp_valid), 1);
      i_rsp_ready = 1'b1;
      g = 0;
      while (!clk_en && g < 100) begin tick(); g++; end
      tick();
      i_rsp_ready = 1'b0;
      chk("rsp_clr", 32'(o_rsp_valid), 0);
    end else begin
      while (!o_cmd_ready && g < 2000) begin tick(); g++; end
    end
    chk("back_idle", 32'(o_cmd_ready), 1);
    chk("nbytes", got.size(), exp_q.size());
    for (int i = 0; i < got.size() && i < exp_q.size(); i++)
      chk($sformatf("byte%0d", i), 32'(got[i]), 32'(exp_q[i]));
  endtask

  initial begin
    int g, sel, dly;
    logic [31:0] a;
    logic [2:0]  op;
    rst = 1'b1; clk_en = 1'b1; i_cmd_valid = 1'b0; i_cmd_op = '0; i_cmd_addr = '0;
    i_cmd_data = '0; i_rsp_ready = 1'b0; i_out_ready = 1'b1; i_valid = 1'b0; i_data = '0;
    is_rd = 1'b0; waiting = 1'b0; answered = 1'b0; wcnt = 0; r_delay = -1; r_data = '0;
    @(negedge clk);
    tick(); tick();
    rst = 1'b0;
    chk("rst_ovalid", 32'(o_valid), 0);
    chk("rst_odata", 32'(o_data), 0);
    chk("rst_rspv", 32'(o_rsp_valid), 0);
    chk("rst_rspto", 32'(o_rsp_timeout), 0);
    chk("rst_rspd", 32'(o_rsp_data), 0);
    chk("rst_cready", 32'(o_cmd_ready), 1);
    chk("rst_inready", 32'(o_in_ready), 1);

    run_cmd(3'd4, 32'h0000_1234, 8'hAB, -1, 8'h00);
    run_cmd(3'd4, 32'h0000_1235, 8'hCD, -1, 8'h00);
    run_cmd(3'd4, 32'h0000_1235, 8'hEF, -1, 8'h00);
    run_cmd(3'd3, 32'h0000_1235, 8'h00, 10, 8'h5A);
    run_cmd(3'd3, 32'h0000_1235, 8'h00, -1, 8'h00);
    run_cmd(3'd4, 32'h0000_1235, 8'h22, -1, 8'h00);
    rdy_mode = 1; en_mode = 1;
    run_cmd(3'd2, 32'h0, 8'h00, -1, 8'h00);
    run_cmd(3'd4, 32'h0000_1235, 8'h11, -1, 8'h00);

    // Reset part way through a WRITE, then a stray byte while idle.
    rdy_mode = 0; en_mode = 0;
    tick();
    got.delete();
    i_cmd_op = 3'd4; i_cmd_addr = 32'h0000_4321; i_cmd_data = 8'h99; i_cmd_valid = 1'b1;
    g = 0;
    while (!(o_cmd_ready && clk_en) && g < 50) begin tick(); g++; end
    tick();
    i_cmd_valid = 1'b0;
    g = 0;
    while (got.size() < 3 && g < 50) begin tick(); g++; end
    chk("mid_bytes", got.size(), 3);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    mcv = 1'b0;
    chk("mid_ovalid", 32'(o_valid), 0);
    chk("mid_cready", 32'(o_cmd_ready), 1);
    i_valid = 1'b1; i_data = 8'h77;
    chk("stray_inrdy", 32'(o_in_ready), 1);
    tick(); tick(); tick();
    chk("stray_norsp", 32'(o_rsp_valid), 0);
    chk("stray_idle", 32'(o_cmd_ready), 1);
    run_cmd(3'd4, 32'h0000_4321, 8'h5C, -1, 8'h00);

    for (int n = 0; n < 40; n++) begin
      rdy_mode = $urandom_range(2);
      en_mode  = $urandom_range(1);
      op  = 3'($urandom_range(7));
      sel = $urandom_range(4);
      case (sel)
        0: a = 32'h0000_1234;
        1: a = 32'h0000_1235;
        2: a = 32'h0001_1235;
        3: a = 32'hDEAD_1235;
        default: a = $urandom;
      endcase
      dly = ($urandom_range(3) == 0) ? -1 : int'($urandom_range(12));
      run_cmd(op, a, 8'($urandom), dly, 8'($urandom));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/bios_host.md
Name: bios_host

Overview:
- Host-side initiator for the BIOS byte-command protocol.
- Accepts high-level requests (NOP, BOOT, RST, READ addr, WRITE addr/data) on a valid/ready command port.
- Serialises each request into BIOS opcode and argument bytes on an AXI-stream byte output, and collects the single response byte a READ produces.
- Sits between a loader/debug master and the UART byte path that feeds the bios block. Includes an address cache so that unchanged address halves are not re-sent.

Parameters:
ADDR_WIDTH, 31, MSB index of address bus (bus is ADDR_WIDTH+1 bits; only 32-bit supported)
TIMEOUT_CYCLES, 65535, clk_en cycles to wait for a READ response byte before timing out (>=1)

Ports:
clk  input  1  clock
rst  input  1  synchronous active-high reset
clk_en  input  1  all state/handshakes advance only when high
i_cmd_valid  input  1  request valid
o_cmd_ready  output  1  high only in S_IDLE
i_cmd_op  input  3  host_op_t
i_cmd_addr  input  ADDR_WIDTH+1  byte address (READ/WRITE)
i_cmd_data  input  8  write byte (WRITE)
o_rsp_valid  output  1  READ result valid
i_rsp_ready  input  1  result accepted
o_rsp_data  output  8  read byte (0 on timeout)
o_rsp_timeout  output  1  response timed out
o_data  output  8  AXI byte out to bios
o_valid  output  1  byte out valid
i_out_ready  input  1  sink ready
i_data  input  8  AXI byte in from bios
i_valid  input  1  byte in valid
o_in_ready  output  1  high in S_IDLE and S_WAIT_RSP

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high. rst overrides clk_en.
- Reset: state=S_IDLE, o_valid=0, o_rsp_valid=0, o_rsp_timeout=0, o_rsp_data=0, o_data=0, cache invalid, timeout counter=0.
- Handshakes: a transfer happens only on a clk_en cycle with valid&ready. o_data/o_valid stay stable until accepted. o_valid never depends combinationally on i_out_ready.
- Command capture: on cmd handshake in S_IDLE, op/addr/data are registered. The first output byte appears with o_valid=1 on the next cycle.
- Byte sequences (opcode values per bios_opcode_t):
  - NOP: 0x00
  - BOOT: 0x01
  - RST: 0x02
  - READ: [addr-low] [addr-high] 0x03
  - WRITE: [addr-low] [addr-high] 0x04 data
  - addr-low = 0x05, addr[7:0], addr[15:8]
  - addr-high = 0x06, addr[23:16], addr[31:24]
- Address cache:
  - addr-low is omitted if the cache is valid and addr[15:0] equals the cached value; addr-high likewise for addr[31:16].
  - Cache is loaded (both halves) and marked valid once the last byte of the op byte (0x03/0x04) is accepted.
  - RST and BOOT invalidate the cache when their byte is accepted.
- States: S_IDLE, S_LO_OP, S_LO_A, S_LO_B, S_HI_OP, S_HI_A, S_HI_B, S_CMD_OP, S_CMD_ARG, S_WAIT_RSP, S_RSP. Each byte state advances on output handshake to the next required state.
  - NOP/BOOT/RST: S_IDLE -> S_CMD_OP -> S_IDLE.
  - WRITE: S_CMD_OP -> S_CMD_ARG -> S_IDLE.
  - READ: S_CMD_OP -> S_WAIT_RSP.
- S_WAIT_RSP:
  - First accepted input byte goes to o_rsp_data with o_rsp_timeout=0; move to S_RSP.
  - Counter increments per clk_en cycle. On reaching TIMEOUT_CYCLES: o_rsp_data=0, o_rsp_timeout=1, move to S_RSP, and invalidate the cache.
- S_RSP: o_rsp_valid=1 until i_rsp_ready handshake, then S_IDLE and counter cleared.
- Input outside S_WAIT_RSP: bytes accepted in S_IDLE are discarded (stray flush). o_in_ready=0 in all other states.
- Illegal op: i_cmd_op values 5..7 are sent as a single 0x00 (NOP).
- Simultaneity: cmd handshake and stray-byte discard may coincide in S_IDLE; both take effect.
- Reset mid-sequence: the partial byte stream is abandoned, o_valid drops next cycle, and the cache is invalidated.

Decomposition:
- Package bios_pkg holds:
  - bios_opcode_t (shared with bios; 0..6 as above)
  - host_op_t: HOP_NOP=0, HOP_BOOT=1, HOP_RST=2, HOP_READ=3, HOP_WRITE=4
  - bios_host_state_t
- No sub-module required; the output byte register is inline.

Test Plan:
- WRITE addr=0x0000_1234 data=0xAB after reset, sink always ready -> bytes 05 34 12 06 00 00 04 AB, then o_cmd_ready=1.
- Follow with WRITE addr=0x0000_1235 data=0xCD -> bytes 05 35 12 04 CD (high half skipped); then WRITE 0x0000_1235 0xEF -> 04 EF only.
- READ addr=0x0000_1235, bench answers 0x5A after 10 cycles -> bytes 04-less sequence 03 only; o_rsp_valid=1, o_rsp_data=0x5A, timeout=0; held until i_rsp_ready.
- READ with no answer, TIMEOUT_CYCLES=16 -> o_rsp_valid after 16 clk_en cycles, data=0x00, timeout=1; next WRITE resends both address halves.
- RST then WRITE 0x0000_1235 0x11 with i_out_ready toggling 1/0 -> bytes 02, then full 05 35 12 06 00 00 04 11; o_data stable while stalled; clk_en=0 cycles freeze everything.
- Assert rst after 3 bytes of a WRITE -> o_valid=0 next cycle; o_cmd_ready=1; stray input byte in S_IDLE consumed and no rsp produced.
